// File: rtl/event_chunk_feeder.sv
// Round-robin chunk readout from SURF source FIFOs into the 64-bit payload stream.
// Each granted source yields exactly CHUNK_LEN words; a stalled source is zero-padded after TIMEOUT idle cycles.
module event_chunk_feeder #(
    parameter int NUM_SRC   = 4,
    parameter int CHUNK_LEN = 384,
    parameter int TIMEOUT   = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      chunk_avail_i,
    input  logic [64*NUM_SRC-1:0]   s_tdata,
    input  logic [NUM_SRC-1:0]      s_tvalid,
    output logic [NUM_SRC-1:0]      s_tready,
    input  logic                    space_avail_i,
    output logic [63:0]             payload_o,
    output logic                    payload_valid_o,
    output logic                    payload_last_o,
    output logic [2:0]              chunk_src_o,
    output logic                    chunk_done_o,
    output logic                    timeout_err_o
);

    localparam int CNT_W  = $clog2(CHUNK_LEN);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CHUNK_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);
    localparam logic [3:0]        NSRC4      = 4'(NUM_SRC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_PAD    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sel_q, sel_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [63:0]         payload_q, payload_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [2:0]          src_q, src_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [NUM_SRC-1:0]  rot_s;
    logic [2:0]          off_s;
    logic [3:0]          sum_s;
    logic [2:0]          pick_s;
    logic                pick_vld_s;
    logic [NUM_SRC-1:0]  sel_oh_s;
    logic [63:0]         sel_data_s;
    logic                beat_s;
    logic [IDLE_W-1:0]   idle_inc_s;

    // Round-robin pick: rotate the request vector so bit 0 is ptr+1, take the lowest set bit.
    always_comb begin
        rot_s = NUM_SRC'({chunk_avail_i, chunk_avail_i} >> (4'(ptr_q) + 4'd1));
        off_s = 3'd0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (rot_s[j]) begin
                off_s = 3'(j);
            end else begin
                off_s = off_s;
            end
        end
        sum_s      = 4'(ptr_q) + 4'd1 + 4'(off_s);
        pick_s     = (sum_s >= NSRC4) ? 3'(sum_s - NSRC4) : 3'(sum_s);
        pick_vld_s = |chunk_avail_i;
    end

    // Decode the granted source into a one-hot and mux its data word.
    always_comb begin
        sel_oh_s   = '0;
        sel_data_s = 64'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_q == 3'(k)) begin
                sel_oh_s[k] = 1'b1;
                sel_data_s  = s_tdata[64*k +: 64];
            end else begin
                sel_oh_s[k] = 1'b0;
            end
        end
    end

    assign s_tready   = (state_q == ST_STREAM) ? sel_oh_s : '0;
    assign beat_s     = |(s_tvalid & s_tready);
    assign idle_inc_s = idle_q + {{(IDLE_W-1){1'b0}}, 1'b1};

    // Next-state and next-output logic; payload outputs default to zero every cycle.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        payload_d = 64'd0;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        src_d     = src_q;
        done_d    = 1'b0;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (space_avail_i && pick_vld_s) begin
                    sel_d   = pick_s;
                    src_d   = pick_s;
                    ptr_d   = pick_s;
                    cnt_d   = '0;
                    idle_d  = '0;
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (beat_s) begin
                    payload_d = sel_data_s;
                    valid_d   = 1'b1;
                    cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    idle_d    = '0;
                    if (cnt_q == CNT_LAST) begin
                        last_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    idle_d = idle_inc_s;
                    if (idle_inc_s == IDLE_LIMIT) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_PAD: begin
                // Zero fill keeps downstream framing intact when a source dies mid-chunk.
                valid_d = 1'b1;
                err_d   = 1'b1;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    last_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= 3'd0;
            ptr_q     <= 3'(NUM_SRC - 1);
            cnt_q     <= '0;
            idle_q    <= '0;
            payload_q <= 64'd0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            src_q     <= 3'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            payload_q <= payload_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            src_q     <= src_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign payload_o       = payload_q;
    assign payload_valid_o = valid_q;
    assign payload_last_o  = last_q;
    assign chunk_src_o     = src_q;
    assign chunk_done_o    = done_q;
    assign timeout_err_o   = err_q;

endmodule

// File: tb/tb_event_chunk_feeder.sv
// Directed bench for event_chunk_feeder: table of arbitration vectors plus
// hand-written space-hold, timeout-pad and mid-chunk reset sequences.
module tb_event_chunk_feeder;

    localparam int N  = 4;
    localparam int L  = 384;
    localparam int TO = 1023;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    chunk_avail_i;
    logic [64*N-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic            space_avail_i;
    logic [63:0]     payload_o;
    logic            payload_valid_o;
    logic            payload_last_o;
    logic [2:0]      chunk_src_o;
    logic            chunk_done_o;
    logic            timeout_err_o;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int last_cyc = -1;
    int src_cnt[N];

    typedef struct {
        logic [N-1:0] avail;
        bit           rnd;
        int           exp_src;
    } vec_t;

    vec_t vecs[9];

    event_chunk_feeder #(.NUM_SRC(N), .CHUNK_LEN(L), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .chunk_avail_i   (chunk_avail_i),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .space_avail_i   (space_avail_i),
        .payload_o       (payload_o),
        .payload_valid_o (payload_valid_o),
        .payload_last_o  (payload_last_o),
        .chunk_src_o     (chunk_src_o),
        .chunk_done_o    (chunk_done_o),
        .timeout_err_o   (timeout_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word(input int k, input int n);
        return {16'hC0DE, 8'(k), 8'h5A, 32'(n)};
    endfunction

    task automatic drive_data();
        for (int k = 0; k < N; k++) s_tdata[64*k +: 64] = word(k, src_cnt[k]);
    endtask

    // Source model: a FIFO advances its read pointer on each accepted beat.
    task automatic tick();
        logic [N-1:0] beat;
        beat = s_tready & s_tvalid;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) if (beat[k]) src_cnt[k]++;
        drive_data();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_chunk(input logic [N-1:0] avail, input int exp_src, input bit rnd,
                             input int stop_after, input logic exp_err, input string name);
        int nvalid = 0, nlast = 0, ndone = 0, bad_data = 0, bad_rdy = 0;
        int last_pos = -1, first_cyc = -1, pad_start = -1, last_data = -1;
        int base, prev_last;
        logic [63:0] exp;
        base          = src_cnt[exp_src];
        prev_last     = last_cyc;
        chunk_avail_i = avail;
        space_avail_i = 1'b1;
        for (int c = 0; c < 3000 && ndone == 0; c++) begin
            if (stop_after >= 0 && (src_cnt[exp_src] - base) >= stop_after) s_tvalid = '0;
            else if (rnd) s_tvalid = N'($urandom_range(0, (1 << N) - 1));
            else s_tvalid = '1;
            tick();
            if ((s_tready & ~(N'(1) << exp_src)) != '0) bad_rdy++;
            if (payload_valid_o) begin
                exp = (stop_after >= 0 && nvalid >= stop_after) ? 64'd0 : word(exp_src, base + nvalid);
                if (payload_o !== exp) bad_data++;
                if (first_cyc < 0) first_cyc = cyc;
                if (stop_after >= 0 && nvalid == stop_after - 1) last_data = cyc;
                if (stop_after >= 0 && nvalid == stop_after) pad_start = cyc;
                nvalid++;
            end
            if (payload_last_o) begin
                nlast++;
                last_pos = payload_valid_o ? nvalid : -2;
                last_cyc = cyc;
            end
            if (chunk_done_o) ndone++;
        end
        chk({name, " words"},     64'(nvalid),   64'(L));
        chk({name, " last cnt"},  64'(nlast),    64'd1);
        chk({name, " last pos"},  64'(last_pos), 64'(L));
        chk({name, " done"},      64'(ndone),    64'd1);
        chk({name, " src"},       64'(chunk_src_o), 64'(exp_src));
        chk({name, " data errs"}, 64'(bad_data), 64'd0);
        chk({name, " tready"},    64'(bad_rdy),  64'd0);
        chk({name, " err flag"},  64'(timeout_err_o), 64'(exp_err));
        if (prev_last >= 0) chk({name, " gap>=2"}, 64'(first_cyc - prev_last >= 3), 64'd1);
        if (stop_after >= 0) chk({name, " idle span"}, 64'(pad_start - last_data), 64'(TO + 1));
    endtask

    initial begin
        int bad;
        int nv;
        vecs[0] = '{4'b1111, 1'b0, 0};
        vecs[1] = '{4'b1111, 1'b0, 1};
        vecs[2] = '{4'b1111, 1'b0, 2};
        vecs[3] = '{4'b1111, 1'b0, 3};
        vecs[4] = '{4'b0100, 1'b1, 2};
        vecs[5] = '{4'b1001, 1'b0, 3};
        vecs[6] = '{4'b1001, 1'b0, 0};
        vecs[7] = '{4'b0010, 1'b1, 1};
        vecs[8] = '{4'b0011, 1'b0, 0};

        for (int k = 0; k < N; k++) src_cnt[k] = 0;
        rst           = 1'b1;
        chunk_avail_i = '0;
        s_tvalid      = '0;
        space_avail_i = 1'b0;
        drive_data();
        repeat (3) tick();
        chk("reset valid", 64'(payload_valid_o), 64'd0);
        chk("reset data",  payload_o,            64'd0);
        chk("reset tready", 64'(s_tready),       64'd0);
        chk("reset src",   64'(chunk_src_o),     64'd0);
        chk("reset done",  64'(chunk_done_o),    64'd0);
        chk("reset err",   64'(timeout_err_o),   64'd0);
        rst = 1'b0;

        // Back-to-back chunks, arbitration order and content.
        for (int v = 0; v < 9; v++)
            run_chunk(vecs[v].avail, vecs[v].exp_src, vecs[v].rnd, -1, 1'b0, $sformatf("vec%0d", v));

        // No room downstream: nothing may move until space is granted.
        space_avail_i = 1'b0;
        chunk_avail_i = 4'b0010;
        s_tvalid      = '1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (s_tready != '0 || payload_valid_o) bad++;
        end
        chk("space hold", 64'(bad), 64'd0);
        space_avail_i = 1'b1;
        tick();
        chk("space start", 64'(s_tready), 64'b0010);
        run_chunk(4'b0010, 1, 1'b0, -1, 1'b0, "space");

        // Source 0 dies after 100 words: pad with zeros, sticky error.
        run_chunk(4'b0001, 0, 1'b0, 100, 1'b1, "timeout");
        run_chunk(4'b0100, 2, 1'b1, -1, 1'b1, "sticky");

        // Reset in the middle of a chunk.
        chunk_avail_i = '1;
        s_tvalid      = '1;
        nv = 0;
        for (int c = 0; c < 1000 && nv < 200; c++) begin
            tick();
            if (payload_valid_o) nv++;
        end
        chk("pre-rst words", 64'(nv), 64'd200);
        chk("pre-rst src", 64'(chunk_src_o), 64'd3);
        rst = 1'b1;
        tick();
        chk("mid-rst valid", 64'(payload_valid_o), 64'd0);
        chk("mid-rst last",  64'(payload_last_o),  64'd0);
        chk("mid-rst data",  payload_o,            64'd0);
        chk("mid-rst tready", 64'(s_tready),       64'd0);
        chk("mid-rst src",   64'(chunk_src_o),     64'd0);
        chk("mid-rst err",   64'(timeout_err_o),   64'd0);
        rst = 1'b0;
        last_cyc = -1;
        run_chunk('1, 0, 1'b0, -1, 1'b0, "post-rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
